rf_writeback_arbiter: RTL

Writeback-side driver for the 32x32 register file's single write port. Merges single-cycle ALU results and long-latency (load/multi-cycle) results onto one registered write port. Buffers long-latency results in a small FIFO and guarantees them forward progress. Keeps a per-register pending scoreboard so the issue stage can stall on destinations that are not yet written.

---
 rtl/rf_writeback_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: merges single-cycle ALU results and queued
// long-latency results onto one registered write port, with a pending scoreboard.
module rf_writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        aluValid,
  output logic        aluReady,
  input  logic [4:0]  aluReg,
  input  logic [31:0] aluData,
  input  logic        memValid,
  output logic        memReady,
  input  logic [4:0]  memReg,
  input  logic [31:0] memData,
  input  logic        issueMark,
  input  logic [4:0]  issueReg,
  input  logic [4:0]  query1,
  input  logic [4:0]  query2,
  output logic        busy1,
  output logic        busy2,
  output logic        writeEnable,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [4:0]    fifo_reg_q  [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   pending_q, pending_d;
  logic          we_q, src_mem_q;
  logic [4:0]    reg_q;
  logic [31:0]   data_q;

  logic fifo_empty, fifo_full, starved;
  logic alu_fire, mem_fire, push, pop;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    starved    = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
    aluReady   = !areset && !starved;
    memReady   = !areset && !fifo_full;
    alu_fire   = aluValid && aluReady;
    mem_fire   = memValid && memReady;
    // Writes to x0 are accepted but never occupy a FIFO slot.
    push       = mem_fire && (memReg != '0);
    pop        = !areset && !alu_fire && !fifo_empty;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_fire && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Clear applied before set so a same-cycle mark on the committing register wins.
  always_comb begin
    pending_d = pending_q;
    if (we_q && src_mem_q) begin
      pending_d[reg_q] = 1'b0;
    end
    if (!areset && issueMark && (issueReg != '0)) begin
      pending_d[issueReg] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= memReg;
      fifo_data_q[wr_ptr_q] <= memData;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      we_q      <= 1'b0;
      src_mem_q <= 1'b0;
      reg_q     <= '0;
      data_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + AW'(push);
      rd_ptr_q  <= rd_ptr_q + AW'(pop);
      count_q   <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      starve_q  <= starve_d;
      pending_q <= pending_d;
      if (alu_fire) begin
        we_q      <= (aluReg != '0);
        reg_q     <= aluReg;
        data_q    <= aluData;
        src_mem_q <= 1'b0;
      end else if (pop) begin
        we_q      <= 1'b1;
        reg_q     <= fifo_reg_q[rd_ptr_q];
        data_q    <= fifo_data_q[rd_ptr_q];
        src_mem_q <= 1'b1;
      end else begin
        we_q      <= 1'b0;
        src_mem_q <= 1'b0;
      end
    end
  end

  assign writeEnable = we_q;
  assign writeReg    = reg_q;
  assign writeData   = data_q;
  assign busy1       = pending_q[query1];
  assign busy2       = pending_q[query2];

endmodule
